// File: rtl/imem_fetch_port.sv
// imem_fetch_port: word-organised instruction store with a byte-address
// fetch port, valid/ready request and response handshakes, programmable
// read wait states, and alignment and range fault reporting. A separate
// write port loads programs; it works in any FSM state.
//
// Ports:
//   CLK        clock; all state changes on the rising edge
//   Reset_L    asynchronous active-low reset
//   req_valid  fetch request valid
//   req_ready  request can be accepted (high only in IDLE)
//   req_addr   fetch byte address, latched when the request is accepted
//   rsp_valid  response valid
//   rsp_ready  consumer accepts the response
//   rsp_data   instruction word (zero on a fault)
//   rsp_fault  request was misaligned or out of range
//   prog_we    program write strobe
//   prog_addr  word index for the program write
//   prog_data  program write data
//   busy       FSM is not in IDLE
//
// Optional feature, enabled by defining IMEM_LAST_HIT_EN: the block records
// the last word index it returned. A repeat fetch of that word skips the
// wait states and responds with latency 1.
module imem_fetch_port #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     CLK,
  input  logic                     Reset_L,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_fault,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic                     busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // The counter only needs to hold RD_LAT-1.
  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               fault_q, fault_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   req_idx;
  logic               req_fault;
  logic               accept;
  logic               hit;
  // A non-fault capture into RESP happens on this edge, for word cap_idx.
  logic               cap_ok;
  logic [IDX_W-1:0]   cap_idx;

  assign req_idx = req_addr[IDX_W+1:2];
  // Any set bit at or above IDX_W+2 puts the word index outside the array.
  assign req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);
  assign accept = req_valid && (state_q == StIdle);

  // Array contents are not reset. The write lands at the edge, so a read
  // captured on that same edge still sees the old word.
  always_ff @(posedge CLK) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

`ifdef IMEM_LAST_HIT_EN
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic             last_vld_q, last_vld_d;

  assign hit = last_vld_q && (last_idx_q == req_idx);

  always_comb begin
    last_idx_d = last_idx_q;
    last_vld_d = last_vld_q;
    if (accept && req_fault) begin
      last_vld_d = 1'b0;
    end
    if (cap_ok) begin
      last_idx_d = cap_idx;
      last_vld_d = 1'b1;
    end
    // A write to the recorded word always invalidates it. This also covers
    // a write that lands on the same edge the word is recorded.
    if (prog_we && (prog_addr == last_idx_d)) begin
      last_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      last_idx_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      last_idx_q <= last_idx_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    fault_d = fault_q;
    cap_ok  = 1'b0;
    cap_idx = idx_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          idx_d = req_idx;
          if (req_fault) begin
            state_d = StResp;
            fault_d = 1'b1;
            data_d  = '0;
          end else if ((RD_LAT == 1) || hit) begin
            // The capture reads straight from the request address because
            // the latched copy only becomes visible after this edge.
            state_d = StResp;
            fault_d = 1'b0;
            data_d  = mem[req_idx];
            cap_ok  = 1'b1;
            cap_idx = req_idx;
          end else begin
            state_d = StWait;
            cnt_d   = CNT_W'(RD_LAT - 1);
          end
        end
      end

      StWait: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = StResp;
          fault_d = 1'b0;
          data_d  = mem[idx_q];
          cap_ok  = 1'b1;
          cap_idx = idx_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      StResp: begin
        // Data and fault hold while the consumer stalls; data also holds
        // after the response is consumed.
        if (rsp_ready) begin
          state_d = StIdle;
          fault_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_data  = data_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed testbench for imem_fetch_port (ADDR_W=64, DATA_W=32, DEPTH=64,
// RD_LAT=2). Inputs are driven and outputs sampled on the falling edge.
module tb_imem_fetch_port;

  logic        CLK;
  logic        Reset_L;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        busy;

  int checks;
  int failures;

  imem_fetch_port #(
    .ADDR_W(64),
    .DATA_W(32),
    .DEPTH (64),
    .RD_LAT(2)
  ) dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_fault(rsp_fault),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .busy     (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic prog_write(input logic [5:0] idx, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_addr = idx;
    prog_data = data;
    @(negedge CLK);
    prog_we   = 1'b0;
  endtask

  // Issue one fetch from a falling edge with the DUT idle. wr_at selects an
  // optional program write: 1 lands on the accept edge, 2 on the edge after.
  // Returns at the falling edge where rsp_valid is first seen.
  task automatic do_fetch(input logic [63:0] addr, input int wr_at,
                          input logic [5:0] wr_idx, input logic [31:0] wr_data,
                          output int lat, output logic [31:0] data,
                          output logic fault);
    check("req_ready_before_fetch", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    prog_addr = wr_idx;
    prog_data = wr_data;
    prog_we   = (wr_at == 1);
    @(negedge CLK);
    req_valid = 1'b0;
    prog_we   = (wr_at == 2);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge CLK);
      prog_we = 1'b0;
      lat++;
    end
    prog_we = 1'b0;
    data  = rsp_data;
    fault = rsp_fault;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
  endtask

  int          lat;
  logic [31:0] data;
  logic        fault;

  initial begin
    checks    = 0;
    failures  = 0;
    Reset_L   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("rst_rsp_fault", {63'd0, rsp_fault}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    Reset_L = 1'b1;
    @(negedge CLK);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Load program.
    prog_write(6'd0, 32'hF84003E9);
    prog_write(6'd1, 32'hF84083EA);
    prog_write(6'd2, 32'hF84103EB);
    prog_write(6'd3, 32'hF84183EC);

    // Normal read: latency RD_LAT.
    do_fetch(64'h8, 0, 6'd0, 32'd0, lat, data, fault);
    check("f8_lat", 64'(lat), 64'd2);
    check("f8_data", {32'd0, data}, 64'hF84103EB);
    check("f8_fault", {63'd0, fault}, 64'd0);
    consume();

    // Misaligned: fault with latency 1.
    do_fetch(64'h6, 0, 6'd0, 32'd0, lat, data, fault);
    check("f6_lat", 64'(lat), 64'd1);
    check("f6_data", {32'd0, data}, 64'd0);
    check("f6_fault", {63'd0, fault}, 64'd1);
    consume();

    // One word past the end.
    do_fetch(64'h100, 0, 6'd0, 32'd0, lat, data, fault);
    check("f100_lat", 64'(lat), 64'd1);
    check("f100_fault", {63'd0, fault}, 64'd1);
    check("f100_data", {32'd0, data}, 64'd0);
    consume();

    // Top address bit set must not alias onto word 0.
    do_fetch(64'h8000_0000_0000_0000, 0, 6'd0, 32'd0, lat, data, fault);
    check("fmsb_fault", {63'd0, fault}, 64'd1);
    consume();

    // Last word of the array is in range.
    do_fetch(64'hFC, 0, 6'd0, 32'd0, lat, data, fault);
    check("ffc_lat", 64'(lat), 64'd2);
    check("ffc_fault", {63'd0, fault}, 64'd0);
    consume();

    // Consumer stall: response holds.
    do_fetch(64'h0, 0, 6'd0, 32'd0, lat, data, fault);
    check("f0_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check("stall_data", {32'd0, rsp_data}, 64'hF84003E9);
      check("stall_req_ready", {63'd0, req_ready}, 64'd0);
    end
    consume();
    check("post_consume_valid", {63'd0, rsp_valid}, 64'd0);
    check("post_consume_busy", {63'd0, busy}, 64'd0);
    check("post_consume_ready", {63'd0, req_ready}, 64'd1);
    check("post_consume_data", {32'd0, rsp_data}, 64'hF84003E9);

    // Write on the accept edge lands before capture: new data.
    do_fetch(64'hC, 1, 6'd3, 32'hDEADBEEF, lat, data, fault);
    check("wr_early_lat", 64'(lat), 64'd2);
    check("wr_early_data", {32'd0, data}, 64'hDEADBEEF);
    consume();

    // Move away from word 3 before the next test.
    do_fetch(64'h4, 0, 6'd0, 32'd0, lat, data, fault);
    check("f4_data", {32'd0, data}, 64'hF84083EA);
    consume();

    // Write on the capture edge: old data returned.
    do_fetch(64'hC, 2, 6'd3, 32'h12345678, lat, data, fault);
    check("wr_cap_lat", 64'(lat), 64'd2);
    check("wr_cap_data", {32'd0, data}, 64'hDEADBEEF);
    consume();

    // The capture-edge write did land in the array.
    do_fetch(64'hC, 0, 6'd0, 32'd0, lat, data, fault);
    check("wr_cap_readback", {32'd0, data}, 64'h12345678);
    consume();

    // Reset during WAIT aborts the transaction.
    req_valid = 1'b1;
    req_addr  = 64'h4;
    @(negedge CLK);
    req_valid = 1'b0;
    check("abort_in_wait_busy", {63'd0, busy}, 64'd1);
    check("abort_in_wait_valid", {63'd0, rsp_valid}, 64'd0);
    #1 Reset_L = 1'b0;
    #1;
    check("abort_valid", {63'd0, rsp_valid}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    do_fetch(64'h4, 0, 6'd0, 32'd0, lat, data, fault);
    check("after_abort_lat", 64'(lat), 64'd2);
    check("after_abort_data", {32'd0, data}, 64'hF84083EA);
    check("after_abort_fault", {63'd0, fault}, 64'd0);
    consume();

`ifdef IMEM_LAST_HIT_EN
    // Repeat of the last word is a hit.
    do_fetch(64'h4, 0, 6'd0, 32'd0, lat, data, fault);
    check("hit_lat", 64'(lat), 64'd1);
    check("hit_data", {32'd0, data}, 64'hF84083EA);
    consume();
    // A write to that word invalidates the hit.
    prog_write(6'd1, 32'hCAFEF00D);
    do_fetch(64'h4, 0, 6'd0, 32'd0, lat, data, fault);
    check("miss_after_wr_lat", 64'(lat), 64'd2);
    check("miss_after_wr_data", {32'd0, data}, 64'hCAFEF00D);
    consume();
`else
    // Without the feature a repeat fetch still takes RD_LAT cycles.
    do_fetch(64'h4, 0, 6'd0, 32'd0, lat, data, fault);
    check("repeat_lat", 64'(lat), 64'd2);
    check("repeat_data", {32'd0, data}, 64'hF84083EA);
    consume();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
